// File: rtl/rc4_phase_sequencer.sv
// RC4 phase sequencer: steps the init, shuffle and decrypt engines in order,
// owns the shared S-memory port and guards each phase with a watchdog.
module rc4_phase_sequencer #(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_LENGTH     = 8,
  parameter int KEY_LENGTH     = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key_in,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [2:0]                       phase,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key_out,
  output logic                             init_start,
  output logic                             shuf_start,
  output logic                             dec_start,
  input  logic                             init_finished,
  input  logic                             shuf_finished,
  input  logic                             dec_finished,
  input  logic [RAM_LENGTH-1:0]            init_addr,
  input  logic [RAM_WIDTH-1:0]             init_wdata,
  input  logic                             init_we,
  input  logic [RAM_LENGTH-1:0]            shuf_addr,
  input  logic [RAM_WIDTH-1:0]             shuf_wdata,
  input  logic                             shuf_we,
  input  logic [RAM_LENGTH-1:0]            dec_addr,
  input  logic [RAM_WIDTH-1:0]             dec_wdata,
  input  logic                             dec_we,
  output logic [RAM_LENGTH-1:0]            ram_addr,
  output logic [RAM_WIDTH-1:0]             ram_wdata,
  output logic                             ram_we
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_SHUFFLE = 3'd2;
  localparam logic [2:0] S_DECRYPT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]      state;
  logic [2:0]      next_state;
  logic [WD_W-1:0] wd_count;
  logic            active;
  logic            expired;

  assign active  = (state == S_INIT) || (state == S_SHUFFLE) || (state == S_DECRYPT);
  assign expired = active && (wd_count == WD_LAST);

  // A finished pulse is tested before expiry so it wins in the last watchdog cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_INIT;
      S_INIT:    if (init_finished) next_state = S_SHUFFLE;
                 else if (expired)  next_state = S_ERROR;
      S_SHUFFLE: if (shuf_finished) next_state = S_DECRYPT;
                 else if (expired)  next_state = S_ERROR;
      S_DECRYPT: if (dec_finished)  next_state = S_DONE;
                 else if (expired)  next_state = S_ERROR;
      default:   next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      key_out  <= '0;
      wd_count <= '0;
    end else begin
      state <= next_state;
      if (!active && start && !abort) key_out <= key_in;
      if (next_state != state) wd_count <= '0;
      else if (active)         wd_count <= wd_count + WD_W'(1);
    end
  end

  assign phase      = state;
  assign busy       = active;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign init_start = (state == S_INIT);
  assign shuf_start = (state == S_SHUFFLE);
  assign dec_start  = (state == S_DECRYPT);

  // Only the engine owning the current phase can reach the memory port.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (state)
      S_INIT: begin
        ram_addr  = init_addr;
        ram_wdata = init_wdata;
        ram_we    = init_we;
      end
      S_SHUFFLE: begin
        ram_addr  = shuf_addr;
        ram_wdata = shuf_wdata;
        ram_we    = shuf_we;
      end
      S_DECRYPT: begin
        ram_addr  = dec_addr;
        ram_wdata = dec_wdata;
        ram_we    = dec_we;
      end
      default: begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Randomized bench for rc4_phase_sequencer: engine models finish after set
// latencies; expected phase per cycle is derived from latencies and timeout.
module tb_rc4_phase_sequencer;

  localparam int T     = 1500;
  localparam int NEVER = 1000000;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [23:0] key_in;
  logic        busy, done, error;
  logic [2:0]  phase;
  logic [23:0] key_out;
  logic        init_start, shuf_start, dec_start;
  logic        init_finished, shuf_finished, dec_finished;
  logic [7:0]  init_addr, shuf_addr, dec_addr;
  logic [7:0]  init_wdata, shuf_wdata, dec_wdata;
  logic        init_we, shuf_we, dec_we;
  logic [7:0]  ram_addr, ram_wdata;
  logic        ram_we;

  int          lat [1:3];
  logic [7:0]  engAddr [1:3];
  logic [7:0]  engData [1:3];
  logic        engWe [1:3];
  int          initCnt, shufCnt, decCnt;
  logic        spurInit;
  logic [23:0] curKey;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  rc4_phase_sequencer #(
    .RAM_WIDTH(8), .RAM_LENGTH(8), .KEY_LENGTH(3), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .key_in(key_in),
    .busy(busy), .done(done), .error(error), .phase(phase), .key_out(key_out),
    .init_start(init_start), .shuf_start(shuf_start), .dec_start(dec_start),
    .init_finished(init_finished), .shuf_finished(shuf_finished), .dec_finished(dec_finished),
    .init_addr(init_addr), .init_wdata(init_wdata), .init_we(init_we),
    .shuf_addr(shuf_addr), .shuf_wdata(shuf_wdata), .shuf_we(shuf_we),
    .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_we(dec_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we)
  );

  // Engine models: each counts cycles of its own start level and pulses finished on the lat-th.
  always @(posedge clk) begin
    initCnt <= init_start ? initCnt + 1 : 0;
    shufCnt <= shuf_start ? shufCnt + 1 : 0;
    decCnt  <= dec_start  ? decCnt  + 1 : 0;
  end
  assign init_finished = (init_start && initCnt == lat[1] - 1) || spurInit;
  assign shuf_finished = shuf_start && shufCnt == lat[2] - 1;
  assign dec_finished  = dec_start  && decCnt  == lat[3] - 1;
  assign init_addr = engAddr[1];  assign init_wdata = engData[1];  assign init_we = engWe[1];
  assign shuf_addr = engAddr[2];  assign shuf_wdata = engData[2];  assign shuf_we = engWe[2];
  assign dec_addr  = engAddr[3];  assign dec_wdata  = engData[3];  assign dec_we  = engWe[3];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Phase c cycles after the accepted start: each phase lasts min(lat, T) cycles, overrun means ERROR.
  function automatic int expPhase(int c, int abortAt);
    int t, d;
    if (abortAt > 0 && c > abortAt) return 0;
    t = c;
    for (int p = 1; p <= 3; p++) begin
      d = (lat[p] > T) ? T : lat[p];
      if (t <= d) return p;
      if (lat[p] > T) return 5;
      t -= d;
    end
    return 4;
  endfunction

  task automatic checkAll(input int ep, input logic [23:0] expKey);
    checkOutput("phase",      32'(phase),      32'(ep));
    checkOutput("busy",       32'(busy),       32'(ep >= 1 && ep <= 3));
    checkOutput("done",       32'(done),       32'(ep == 4));
    checkOutput("error",      32'(error),      32'(ep == 5));
    checkOutput("init_start", 32'(init_start), 32'(ep == 1));
    checkOutput("shuf_start", 32'(shuf_start), 32'(ep == 2));
    checkOutput("dec_start",  32'(dec_start),  32'(ep == 3));
    checkOutput("ram_addr",   32'(ram_addr),   (ep >= 1 && ep <= 3) ? 32'(engAddr[ep]) : 32'd0);
    checkOutput("ram_wdata",  32'(ram_wdata),  (ep >= 1 && ep <= 3) ? 32'(engData[ep]) : 32'd0);
    checkOutput("ram_we",     32'(ram_we),     (ep >= 1 && ep <= 3) ? 32'(engWe[ep])   : 32'd0);
    checkOutput("key_out",    32'(key_out),    32'(expKey));
  endtask

  // One run: start with key, engines take l1/l2/l3 cycles; optional abort (with a competing
  // start), spurious init_finished and a start pulse while busy, at the given cycles.
  task automatic applyStimulus(input logic [23:0] key, input int l1, input int l2, input int l3,
                               input int abortAt, input int spurAt, input int startAt);
    int len, t, d;
    lat[1] = l1; lat[2] = l2; lat[3] = l3;
    for (int p = 1; p <= 3; p++) begin
      engAddr[p] = 8'($urandom);
      engData[p] = 8'($urandom);
      engWe[p]   = ($urandom_range(0, 3) != 0);
    end
    if (abortAt > 0) len = abortAt + 3;
    else begin
      t = 0;
      for (int p = 1; p <= 3; p++) begin
        d = (lat[p] > T) ? T : lat[p];
        t += d;
        if (lat[p] > T) break;
      end
      len = t + 3;
    end
    curKey = key;
    start  = 1'b1;
    key_in = key;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; spurInit = 1'b0;
      if (c == 1) key_in = 24'($urandom);
      cyc = c;
      checkAll(expPhase(c, abortAt), curKey);
      if (c == abortAt) begin abort = 1'b1; start = 1'b1; key_in = 24'($urandom); end
      if (c == spurAt)  spurInit = 1'b1;
      if (c == startAt) begin start = 1'b1; key_in = 24'($urandom); end
    end
    start = 1'b0; abort = 1'b0; spurInit = 1'b0;
  endtask

  initial begin
    int a, b, e;
    lat[1] = NEVER; lat[2] = NEVER; lat[3] = NEVER;
    for (int p = 1; p <= 3; p++) begin engAddr[p] = 8'hA0 + 8'(p); engData[p] = 8'h50 + 8'(p); engWe[p] = 1'b1; end
    spurInit = 1'b0; abort = 1'b0;
    reset = 1'b1; start = 1'b1; key_in = 24'hABCDEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAll(0, 24'h0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checkAll(0, 24'h0);

    // Nominal run, then timeout in shuffle, then finish exactly at expiry from ERROR.
    applyStimulus(24'h00033C, 256, 1280, 64, 0, 0, 0);
    applyStimulus(24'($urandom), 5, NEVER, 5, 0, 0, 0);
    applyStimulus(24'($urandom), 3, T, 4, 0, 0, 0);
    // Abort mid-shuffle, then a restart whose first phase runs right up to expiry.
    applyStimulus(24'($urandom), 3, 50, 10, 20, 0, 0);
    applyStimulus(24'hFFFFFF, T, 2, 2, 0, 0, 0);
    // Spurious init_finished in shuffle and a start pulse in decrypt are both ignored.
    applyStimulus(24'($urandom), 10, 30, 20, 0, 20, 50);

    for (int i = 0; i < 25; i++) begin
      a = $urandom_range(1, 40); b = $urandom_range(1, 40); e = $urandom_range(1, 40);
      case ($urandom_range(0, 2))
        0: applyStimulus(24'($urandom), a, b, e, $urandom_range(1, a + b + e), 0, 0);
        1: applyStimulus(24'($urandom), a, b, e, 0, a + 1, a + b + 1);
        default: applyStimulus(24'($urandom), a, b, e, 0, 0, 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
